// File: rtl/jpeg_fifo_pkg.sv
// rtl/jpeg_fifo_pkg.sv - shared types and default widths for the JPEG channel FIFO stage
package jpeg_fifo_pkg;

    localparam int DEF_NCH   = 3;
    localparam int DEF_DW    = 32;
    localparam int DEF_OW    = 5;
    localparam int DEF_DEPTH = 16;

    typedef struct packed {
        logic                eob;
        logic [DEF_OW-1:0]   orc;
        logic [DEF_DW-1:0]   data;
    } chan_word_t;

    typedef enum logic {
        LOAD     = 1'b0,
        WAIT_EOB = 1'b1
    } seq_state_t;

endpackage

// File: rtl/jpeg_sync_fifo.sv
// rtl/jpeg_sync_fifo.sv - single-channel show-ahead FIFO with occupancy and sticky overflow
module jpeg_sync_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_do_pop  = i_pop && (r_level != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rdata    = r_mem[r_rd_ptr];
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/jpeg_chan_fifo.sv
// rtl/jpeg_chan_fifo.sv - per-channel bitstream FIFOs drained in strict MCU order onto one ready/valid port
// Optional high-water-mark output enabled by JPEG_CHAN_FIFO_HWM_EN.
module jpeg_chan_fifo
    import jpeg_fifo_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int DW    = DEF_DW,
    parameter int OW    = DEF_OW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NCH-1:0]                        in_valid,
    input  logic [NCH*DW-1:0]                     in_data,
    input  logic [NCH*OW-1:0]                     in_orc,
    input  logic [NCH-1:0]                        in_eob,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DW-1:0]                         out_data,
    output logic [OW-1:0]                         out_orc,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_chan,
    output logic                                  out_eob,
    output logic                                  mcu_done,
    output logic [NCH*($clog2(DEPTH)+1)-1:0]      level,
    output logic [NCH-1:0]                        overflow
`ifdef JPEG_CHAN_FIFO_HWM_EN
    ,
    output logic [NCH*($clog2(DEPTH)+1)-1:0]      hwm
`endif
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          eob;
        logic [OW-1:0] orc;
        logic [DW-1:0] data;
    } word_t;

    word_t          w_head [NCH];
    logic [NCH-1:0] w_empty;
    logic [NCH-1:0] w_pop;

    seq_state_t     r_state;
    seq_state_t     w_state_nxt;
    logic [CW-1:0]  r_cur;
    logic [CW-1:0]  w_cur_nxt;
    logic           w_load;
    logic           w_accept;
    logic           w_mcu;

    logic           r_out_valid;
    word_t          r_out_word;
    logic [CW-1:0]  r_out_chan;
    logic           r_mcu_done;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        word_t w_in;
        assign w_in     = {in_eob[g], in_orc[g*OW +: OW], in_data[g*DW +: DW]};
        assign w_pop[g] = w_load && (r_cur == CW'(g));

        jpeg_sync_fifo #(
            .W     ($bits(word_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .i_push     (in_valid[g]),
            .i_wdata    (w_in),
            .i_pop      (w_pop[g]),
            .o_rdata    (w_head[g]),
            .o_empty    (w_empty[g]),
            .o_level    (level[g*LW +: LW]),
            .o_overflow (overflow[g])
        );
    end

    assign w_accept = r_out_valid && out_ready;

    always_comb begin
        w_load      = 1'b0;
        w_mcu       = 1'b0;
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        case (r_state)
            LOAD: begin
                // Refill in the same cycle the held word leaves, so a block streams without bubbles.
                if (!w_empty[r_cur] && (!r_out_valid || w_accept)) begin
                    w_load = 1'b1;
                    if (w_head[r_cur].eob) begin
                        w_state_nxt = WAIT_EOB;
                    end
                end
            end
            WAIT_EOB: begin
                if (w_accept) begin
                    w_state_nxt = LOAD;
                    w_mcu       = (r_cur == CW'(NCH - 1));
                    w_cur_nxt   = w_mcu ? '0 : r_cur + CW'(1);
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_cur       <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_chan  <= '0;
            r_mcu_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_mcu_done <= w_mcu;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_word  <= w_head[r_cur];
                r_out_chan  <= r_cur;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_word.data;
    assign out_orc   = r_out_word.orc;
    assign out_eob   = r_out_word.eob;
    assign out_chan  = r_out_chan;
    assign mcu_done  = r_mcu_done;

`ifdef JPEG_CHAN_FIFO_HWM_EN
    logic [NCH*LW-1:0] r_hwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwm <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (level[c*LW +: LW] > r_hwm[c*LW +: LW]) begin
                    r_hwm[c*LW +: LW] <= level[c*LW +: LW];
                end
            end
        end
    end

    assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_jpeg_chan_fifo.sv
// tb/tb_jpeg_chan_fifo.sv - self-checking bench for jpeg_chan_fifo with an MCU-order reference model
module tb_jpeg_chan_fifo;

    localparam int NCH   = 3;
    localparam int DW    = 32;
    localparam int OW    = 5;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH*OW-1:0] in_orc = '0;
    logic [NCH-1:0]    in_eob = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [OW-1:0]     out_orc;
    logic [1:0]        out_chan;
    logic              out_eob;
    logic              mcu_done;
    logic [NCH*LW-1:0] level;
    logic [NCH-1:0]    overflow;
`ifdef JPEG_CHAN_FIFO_HWM_EN
    logic [NCH*LW-1:0] hwm;
`endif

    jpeg_chan_fifo #(.NCH(NCH), .DW(DW), .OW(OW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_orc    (in_orc),
        .in_eob    (in_eob),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_orc   (out_orc),
        .out_chan  (out_chan),
        .out_eob   (out_eob),
        .mcu_done  (mcu_done),
        .level     (level),
        .overflow  (overflow)
`ifdef JPEG_CHAN_FIFO_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int checks = 0;

    // Word as seen on the output: {chan, eob, orc, data}.
    logic [39:0] pushq [NCH][$];
    logic [39:0] got_q [$];
    logic [39:0] exp_q [$];
    int          mcu_q [$];
    int          exp_mcu [$];

    function automatic logic [LW-1:0] lvl(input int c);
        return level[c*LW +: LW];
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) pushq[c].delete();
        got_q.delete();
        mcu_q.delete();
    endtask

    task automatic set_push(input int c, input logic eob);
        in_valid[c]          = 1'b1;
        in_eob[c]            = eob;
        in_data[c*DW +: DW]  = $urandom;
        in_orc[c*OW +: OW]   = OW'($urandom);
    endtask

    // Advance one clock: log pre-edge acceptances and pushes, sample #1 after the edge.
    task automatic cycle();
        if (!rst) begin
            if (out_valid && out_ready) got_q.push_back({out_chan, out_eob, out_orc, out_data});
            for (int c = 0; c < NCH; c++)
                if (in_valid[c])
                    pushq[c].push_back({2'(c), in_eob[c], in_orc[c*OW +: OW], in_data[c*DW +: DW]});
        end
        @(posedge clk);
        #1;
        if (mcu_done) mcu_q.push_back(got_q.size());
    endtask

    // Strict MCU order: exhaust channel cur up to its eob, then move to the next channel.
    task automatic model_order();
        logic [39:0] q [NCH][$];
        logic [39:0] w;
        int cur;
        for (int c = 0; c < NCH; c++) q[c] = pushq[c];
        exp_q.delete();
        exp_mcu.delete();
        cur = 0;
        while (q[cur].size() > 0) begin
            w = q[cur].pop_front();
            exp_q.push_back(w);
            if (w[37]) begin
                if (cur == NCH - 1) exp_mcu.push_back(exp_q.size());
                cur = (cur + 1) % NCH;
            end
        end
    endtask

    task automatic drain(output bit ok);
        in_valid  = '0;
        out_ready = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!out_valid && level == '0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_push(0, 1'b0);
            if (i < 4) set_push(1, 1'b0); else in_valid[1] = 1'b0;
            cycle();
        end
        checks++;
        if (overflow !== 3'b001) $display("FAIL pre_reset_overflow got %b exp 001", overflow);
        else passed++;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || overflow !== '0 || mcu_done !== 1'b0)
            $display("FAIL reset_state valid=%b level=%h ovf=%b mcu=%b exp 0", out_valid, level, overflow, mcu_done);
        else passed++;
        checks++;
        if (out_data !== '0 || out_orc !== '0 || out_chan !== '0 || out_eob !== 1'b0)
            $display("FAIL reset_outputs data=%h orc=%h chan=%0d eob=%b exp 0", out_data, out_orc, out_chan, out_eob);
        else passed++;
        rst = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (out_valid !== 1'b0 || level !== '0)
            $display("FAIL reset_discard valid=%b level=%h exp 0/0", out_valid, level);
        else passed++;
        clear_model();
    endtask

    task automatic test_mcu_order();
        bit ok, mok;
        clear_model();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = '0;
            set_push(0, i == 2);
            if (i == 0) set_push(1, 1'b1);
            if (i < 2)  set_push(2, i == 1);
            cycle();
        end
        drain(ok);
        checks++;
        if (!ok) $display("FAIL t2_drain_timeout level=%h valid=%b", level, out_valid); else passed++;
        model_order();
        checks++;
        if (got_q.size() != 6 || exp_q.size() != 6) $display("FAIL t2_count got %0d exp 6", got_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t2_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        mok = (mcu_q.size() == 1) && (mcu_q[0] == 6);
        checks++;
        if (!mok) $display("FAIL t2_mcu_done pulses %0d exp 1 after word 6", mcu_q.size()); else passed++;
    endtask

    task automatic test_strict_order();
        bit ok, early;
        clear_model();
        out_ready = 1'b1;
        in_valid = '0;
        set_push(2, 1'b0);
        cycle();
        in_valid = '0;
        set_push(2, 1'b1);
        set_push(1, 1'b1);
        cycle();
        in_valid = '0;
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) early = 1'b1;
            cycle();
        end
        checks++;
        if (early || out_valid) $display("FAIL t3_stall out_valid got 1 exp 0"); else passed++;
        set_push(0, 1'b1);
        cycle();
        in_valid = '0;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0)
            $display("FAIL t3_first_chan valid=%b chan=%0d exp 1/0", out_valid, out_chan);
        else passed++;
        drain(ok);
        model_order();
        checks++;
        if (!ok || got_q.size() != exp_q.size()) $display("FAIL t3_count got %0d exp %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t3_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_latency_hold();
        bit ok, moved;
        logic [39:0] held;
        clear_model();
        out_ready = 1'b0;
        in_valid = '0;
        set_push(0, 1'b0);
        cycle();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL t4_latency_k out_valid got %b exp 0", out_valid); else passed++;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== pushq[0][0][31:0] || out_chan !== 2'd0)
            $display("FAIL t4_latency_k1 valid=%b data=%h exp 1/%h", out_valid, out_data, pushq[0][0][31:0]);
        else passed++;
        held = {out_chan, out_eob, out_orc, out_data};
        set_push(0, 1'b1);
        set_push(1, 1'b1);
        set_push(2, 1'b1);
        moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            in_valid = '0;
            if (!out_valid || {out_chan, out_eob, out_orc, out_data} !== held) moved = 1'b1;
        end
        checks++;
        if (moved) $display("FAIL t4_hold got %h exp %h", {out_chan, out_eob, out_orc, out_data}, held);
        else passed++;
        drain(ok);
        model_order();
        checks++;
        if (!ok || got_q.size() != 4) $display("FAIL t4_count got %0d exp 4", got_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t4_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        bit ok, mok;
        bit plan [NCH][$];
        int len;
        clear_model();
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < 2; b++) begin
                len = 1 + int'($urandom_range(3));
                for (int i = 0; i < len; i++) plan[c].push_back(i == len - 1);
            end
        for (int t = 0; t < 300; t++) begin
            if (plan[0].size() == 0 && plan[1].size() == 0 && plan[2].size() == 0) break;
            in_valid = '0;
            for (int c = 0; c < NCH; c++)
                if (plan[c].size() > 0 && $urandom_range(1) == 1) set_push(c, plan[c].pop_front());
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        drain(ok);
        model_order();
        checks++;
        if (!ok || got_q.size() != exp_q.size()) $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rnd_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        mok = (mcu_q.size() == exp_mcu.size()) && (exp_mcu.size() == 2);
        for (int i = 0; i < exp_mcu.size() && mok; i++) if (mcu_q[i] != exp_mcu[i]) mok = 1'b0;
        checks++;
        if (!mok) $display("FAIL rnd_mcu_done pulses %0d exp %0d", mcu_q.size(), exp_mcu.size()); else passed++;
        checks++;
        if (overflow !== '0) $display("FAIL rnd_overflow got %b exp 000", overflow); else passed++;
    endtask

    task automatic test_overflow();
        bit ok;
        clear_model();
        out_ready = 1'b0;
        in_valid = '0;
        set_push(0, 1'b1);
        cycle();
        in_valid = '0;
        for (int i = 0; i < 18; i++) begin
            set_push(1, i >= 15);
            cycle();
        end
        in_valid = '0;
        // Cb is not current while the Y block waits, so the last two pushes find it full.
        void'(pushq[1].pop_back());
        void'(pushq[1].pop_back());
        checks++;
        if (lvl(1) !== 5'd16) $display("FAIL t5_level_cb got %0d exp 16", lvl(1)); else passed++;
        checks++;
        if (overflow !== 3'b010) $display("FAIL t5_overflow got %b exp 010", overflow); else passed++;
        set_push(2, 1'b1);
        cycle();
        drain(ok);
        model_order();
        checks++;
        if (!ok || got_q.size() != 18) $display("FAIL t5_count got %0d exp 18", got_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t5_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (overflow[1] !== 1'b1) $display("FAIL t5_sticky got %b exp 1", overflow[1]); else passed++;
    endtask

    task automatic test_full_pushpop();
        bit ok, bad;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_model();
        checks++;
        if (overflow !== '0) $display("FAIL t6_ovf_cleared got %b exp 000", overflow); else passed++;
        out_ready = 1'b0;
        in_valid = '0;
        set_push(0, 1'b1);
        cycle();
        in_valid = '0;
        for (int i = 0; i < 16; i++) begin
            set_push(1, 1'b0);
            cycle();
        end
        in_valid = '0;
        out_ready = 1'b1;
        cycle();
        checks++;
        if (lvl(1) !== 5'd16) $display("FAIL t6_full got %0d exp 16", lvl(1)); else passed++;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_push(1, i == 19);
            cycle();
            if (lvl(1) !== 5'd16 || overflow[1] !== 1'b0) bad = 1'b1;
        end
        in_valid = '0;
        checks++;
        if (bad) $display("FAIL t6_level_hold level=%0d ovf=%b exp 16/0", lvl(1), overflow[1]); else passed++;
        set_push(2, 1'b1);
        cycle();
        drain(ok);
        model_order();
        checks++;
        if (!ok || got_q.size() != 38) $display("FAIL t6_count got %0d exp 38", got_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL t6_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (overflow !== '0) $display("FAIL t6_overflow got %b exp 000", overflow); else passed++;
`ifdef JPEG_CHAN_FIFO_HWM_EN
        checks++;
        if (hwm[1*LW +: LW] !== 5'd16) $display("FAIL t6_hwm got %0d exp 16", hwm[1*LW +: LW]); else passed++;
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_mcu_order();
        test_strict_order();
        test_latency_hold();
        test_random();
        test_overflow();
        test_full_pushpop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
